multiplier_product_accum: RTL

MULTIPLIER_PRODUCT_ACCUM -- requirements
Module: multiplier_product_accum

---
 rtl/multiplier_product_accum_if.sv | 22 ++
 rtl/multiplier_product_accum.sv | 78 +++++++
 2 files changed

// File: rtl/multiplier_product_accum_if.sv
// Product-in / window-sum-out stream bundle for the multiplier product accumulator.
interface multiplier_product_accum_if #(
    parameter int p_width   = 10,
    parameter int acc_width = 12
);
    logic                 istream_val;
    logic                 istream_rdy;
    logic [p_width-1:0]   istream_msg;
    logic                 ostream_val;
    logic                 ostream_rdy;
    logic [acc_width-1:0] ostream_msg;

    modport master (
        output istream_val, istream_msg, ostream_rdy,
        input  istream_rdy, ostream_val, ostream_msg
    );

    modport slave (
        input  istream_val, istream_msg, ostream_rdy,
        output istream_rdy, ostream_val, ostream_msg
    );
endinterface

// File: rtl/multiplier_product_accum.sv
// Sums win_len signed products per window and hands each sum downstream over a val/rdy stream.
module multiplier_product_accum #(
    parameter int p_width   = 10,
    parameter int win_len   = 4,
    parameter int acc_width = p_width + $clog2(win_len)
) (
    input  logic                         clk,
    input  logic                         reset,
    multiplier_product_accum_if.slave    bus
);
    localparam int cnt_w = $clog2(win_len) + 1;
    localparam logic [0:0] st_accum = 1'b0;
    localparam logic [0:0] st_full  = 1'b1;
    localparam logic [cnt_w-1:0] cnt_last = cnt_w'(win_len - 1);

    function automatic logic signed [acc_width-1:0] sign_ext(input logic signed [p_width-1:0] v);
        return acc_width'(v);
    endfunction

    logic [0:0]                  state_p0;
    logic signed [acc_width-1:0] acc_p0;
    logic signed [acc_width-1:0] res_p0;
    logic [cnt_w-1:0]            cnt_p0;
    logic                        vld_p0;
    logic                        in_fire;
    logic signed [acc_width-1:0] prod_ext;
    logic signed [acc_width-1:0] acc_sum;

    // Handshake outputs come only from registered state and ostream_rdy.
    assign vld_p0          = (state_p0 == st_full);
    assign bus.istream_rdy = !vld_p0 || bus.ostream_rdy;
    assign bus.ostream_val = vld_p0;
    assign bus.ostream_msg = res_p0;

    assign in_fire  = bus.istream_val && bus.istream_rdy;
    assign prod_ext = sign_ext(bus.istream_msg);
    assign acc_sum  = acc_p0 + prod_ext;

    // Stage p0: accumulate the window, then park the sum in res until drained.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_p0 <= st_accum;
            acc_p0   <= '0;
            cnt_p0   <= '0;
            res_p0   <= '0;
        end else begin
            case (state_p0)
                st_accum: begin
                    if (in_fire) begin
                        if (cnt_p0 == cnt_last) begin
                            res_p0   <= acc_sum;
                            acc_p0   <= '0;
                            cnt_p0   <= '0;
                            state_p0 <= st_full;
                        end else begin
                            acc_p0 <= acc_sum;
                            cnt_p0 <= cnt_p0 + 1'b1;
                        end
                    end
                end
                st_full: begin
                    if (bus.ostream_rdy) begin
                        state_p0 <= st_accum;
                        // A product arriving on the drain cycle opens the next window.
                        if (bus.istream_val) begin
                            acc_p0 <= prod_ext;
                            cnt_p0 <= cnt_w'(1);
                        end else begin
                            acc_p0 <= '0;
                            cnt_p0 <= '0;
                        end
                    end
                end
                default: state_p0 <= st_accum;
            endcase
        end
    end
endmodule
